// File: rtl/deser_ctrl_pkg.sv
// Shared types for the deserializer capture sequencer: FSM state encoding,
// default frame length and the per-frame status bundle.
// No ports; imported by deser_capture_ctrl.
package deser_ctrl_pkg;

  // Pair groups the deserializer emits per frame; default expected pair count.
  localparam int FRAME_GROUPS  = 324;
  localparam int DEF_EXP_PAIRS = FRAME_GROUPS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_IN_FRAME = 3'd3,
    ST_STOPPING = 3'd4
  } state_e;

  typedef struct packed {
    logic frame_ok;
    logic err_len;
    logic err_timeout;
  } status_t;

endpackage

// File: rtl/deser_capture_ctrl.sv
// Capture sequencer: gates the deserializer enable, tracks frame boundaries
// and pair strobes, checks pair count per frame, counts frames, flags errors.
// Ports: start/stop/num_frames/err_clear from host; frame_start_i/frame_end_i/
// pair_valid_i retimed deserializer pulses; deser_enable, busy, frame_done,
// frame_ok, frames_captured, err_len, err_timeout, state_o back to host/CSR.
module deser_capture_ctrl
  import deser_ctrl_pkg::*;
#(
  parameter int EXP_PAIRS      = DEF_EXP_PAIRS,
  parameter int PAIR_CNT_W     = 10,
  parameter int FRAME_CNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_75mhz,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic                   err_clear,
  input  logic                   frame_start_i,
  input  logic                   frame_end_i,
  input  logic                   pair_valid_i,
  output logic                   deser_enable,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic [FRAME_CNT_W-1:0] frames_captured,
  output logic                   err_len,
  output logic                   err_timeout,
  output logic [2:0]             state_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PAIR_CNT_W-1:0] PAIR_MAX = '1;
  localparam logic [PAIR_CNT_W-1:0] EXP_CNT  = PAIR_CNT_W'(EXP_PAIRS);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [PAIR_CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;
  logic [FRAME_CNT_W-1:0] num_frames_q, num_frames_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   deser_en_q, deser_en_d;
  logic                   frame_done_q, frame_done_d;
  status_t                status_q, status_d;

  logic [PAIR_CNT_W-1:0]  pair_next;
  logic [FRAME_CNT_W-1:0] frames_inc;
  logic                   tmo_hit, len_set, tmo_set, watching;

  always_comb begin
    state_d           = state_q;
    pair_cnt_d        = pair_cnt_q;
    frames_d          = frames_q;
    num_frames_d      = num_frames_q;
    stop_pend_d       = stop_pend_q;
    frame_done_d      = 1'b0;
    status_d.frame_ok = status_q.frame_ok;
    len_set           = 1'b0;
    tmo_set           = 1'b0;

    // Count including a pair strobe in this cycle, saturating at all-ones.
    pair_next  = pair_valid_i ? ((pair_cnt_q == PAIR_MAX) ? PAIR_MAX : pair_cnt_q + PAIR_CNT_W'(1))
                              : pair_cnt_q;
    frames_inc = frames_q + FRAME_CNT_W'(1);
    // Any deserializer activity this cycle restarts the timeout window.
    tmo_hit    = (tmo_q == TMO_LAST) && !frame_start_i && !pair_valid_i;

    unique case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          num_frames_d = num_frames;
          frames_d     = '0;
          state_d      = ST_ARM;
        end
      end
      ST_ARM: state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (stop) begin
          state_d = ST_STOPPING;
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_d = ST_STOPPING;
        end else if (frame_start_i) begin
          pair_cnt_d = PAIR_CNT_W'(pair_valid_i);
          state_d    = ST_IN_FRAME;
        end
      end
      ST_IN_FRAME: begin
        if (stop) stop_pend_d = 1'b1;
        if (frame_end_i) begin
          frame_done_d      = 1'b1;
          status_d.frame_ok = (pair_next == EXP_CNT);
          len_set           = (pair_next != EXP_CNT);
          frames_d          = frames_inc;
          if (stop_pend_q || stop || ((num_frames_q != '0) && (frames_inc == num_frames_q))) begin
            state_d = ST_STOPPING;
          end else if (frame_start_i) begin
            // Back-to-back frame: a coincident pair belongs to the new frame too.
            pair_cnt_d = PAIR_CNT_W'(pair_valid_i);
          end else begin
            state_d = ST_WAIT_SOF;
          end
        end else if (frame_start_i) begin
          // Start without end: flag and resync on the new frame.
          len_set    = 1'b1;
          pair_cnt_d = PAIR_CNT_W'(pair_valid_i);
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_d = ST_STOPPING;
        end else begin
          pair_cnt_d = pair_next;
        end
      end
      ST_STOPPING: begin
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    watching = (state_q == ST_WAIT_SOF) || (state_q == ST_IN_FRAME);
    tmo_d    = (!watching || (state_d != state_q) || frame_start_i || pair_valid_i)
               ? '0 : tmo_q + TMO_W'(1);

    // Sticky errors: a set in the same cycle wins over clear.
    status_d.err_len     = len_set | (status_q.err_len & ~err_clear);
    status_d.err_timeout = tmo_set | (status_q.err_timeout & ~err_clear);

    // Registered enable so the deserializer sees a glitch-free level.
    deser_en_d = (state_d == ST_ARM) || (state_d == ST_WAIT_SOF) || (state_d == ST_IN_FRAME);
  end

  always_ff @(posedge clk_75mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pair_cnt_q   <= '0;
      frames_q     <= '0;
      num_frames_q <= '0;
      tmo_q        <= '0;
      stop_pend_q  <= 1'b0;
      deser_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      pair_cnt_q   <= pair_cnt_d;
      frames_q     <= frames_d;
      num_frames_q <= num_frames_d;
      tmo_q        <= tmo_d;
      stop_pend_q  <= stop_pend_d;
      deser_en_q   <= deser_en_d;
      frame_done_q <= frame_done_d;
      status_q     <= status_d;
    end
  end

  assign deser_enable    = deser_en_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = frame_done_q;
  assign frame_ok        = status_q.frame_ok;
  assign frames_captured = frames_q;
  assign err_len         = status_q.err_len;
  assign err_timeout     = status_q.err_timeout;
  assign state_o         = state_q;

endmodule
